dbf_value_packer: RTL and testbench

//  Downstream stage of the Bloom-filter lookup path: absorbs the 8-bit VALUE/VALUE_WR result stream.

---
 rtl/dbf_pkg.sv | 21 ++
 rtl/dbf_byte_fifo.sv | 73 +++++++
 rtl/dbf_value_packer.sv | 138 +++++++++++++
 tb/tb_dbf_value_packer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dbf_pkg.sv
// Shared definitions for the Bloom-filter value path: widths, packer state
// encoding and the saturating counter helper.
package dbf_pkg;

  localparam int PACK_N = 4;
  localparam int VAL_W  = 8;
  localparam int OUT_W  = 32;
  localparam int CNT_W  = 16;
  localparam int NB_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GATHER,
    ST_EMIT
  } pk_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dbf_byte_fifo.sv
// Single-clock byte FIFO with registered read data (valid one cycle after
// rd_en_i), occupancy count, full flag and registered almost-full flag.
module dbf_byte_fifo
  import dbf_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int AF_THRESH = 56
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wr_en_i,
  input  logic [VAL_W-1:0]  wr_data_i,
  input  logic              rd_en_i,
  output logic [VAL_W-1:0]  rd_data_o,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              af_o
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_LVL   = (ADDR_W+1)'(AF_THRESH);

  logic [VAL_W-1:0]  mem_q [DEPTH];
  logic [VAL_W-1:0]  rd_data_q;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              af_q;
  logic              full, empty, wr_ok, rd_ok;

  assign full  = (count_q == FULL_LVL);
  assign empty = (count_q == '0);
  assign rd_ok = rd_en_i && !empty;
  // A full FIFO can still take a byte when a read frees a slot in the same cycle.
  assign wr_ok = wr_en_i && (!full || rd_ok);

  // Occupancy update: simultaneous write and read leave the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers, count and the almost-full flag (one cycle behind occupancy).
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      af_q     <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      af_q    <= (count_q >= AF_LVL);
    end
  end

  // Storage and registered read port; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    if (rd_ok) rd_data_q <= mem_q[rd_ptr_q];
  end

  assign rd_data_o = rd_data_q;
  assign count_o   = count_q;
  assign full_o    = full;
  assign af_o      = af_q;

endmodule

// File: rtl/dbf_value_packer.sv
// Absorbs the filter's byte result stream into a FIFO, packs up to four bytes
// per 32-bit word (first byte in the low lane) and hands words out over a
// valid/ready handshake. FLUSH or an idle timeout pushes out partial words.
module dbf_value_packer
  import dbf_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int AF_THRESH = 56,
  parameter int TMO_CYC   = 255
) (
  input  logic              SYS_CLK,
  input  logic              RESET_N,
  input  logic              VALUE_WR,
  input  logic [VAL_W-1:0]  VALUE,
  output logic              VALUE_ALLMOSTFULL,
  input  logic              FLUSH,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [OUT_W-1:0]  OUT_DATA,
  output logic [NB_W-1:0]   OUT_BYTES,
  output logic [CNT_W-1:0]  DROP_CNT
);

  localparam int              TMO_W   = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_CYC);
  localparam logic [NB_W-1:0]  NB_FULL = NB_W'(PACK_N);

  pk_state_e         state_q, state_d;
  logic [NB_W-1:0]   nbytes_q, nbytes_d, n_now;
  logic [OUT_W-1:0]  lanes_q, lanes_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [CNT_W-1:0]  drop_q;
  logic              pend_q, flush_q, flush_d;
  logic              rd_en, tmo_hit, flush_pend;
  logic [VAL_W-1:0]  fifo_rd_data;
  logic [ADDR_W:0]   fifo_cnt;
  logic              fifo_full, fifo_empty, fifo_af;

  dbf_byte_fifo #(
    .ADDR_W    (ADDR_W),
    .AF_THRESH (AF_THRESH)
  ) u_fifo (
    .clk_i     (SYS_CLK),
    .rst_n_i   (RESET_N),
    .wr_en_i   (VALUE_WR),
    .wr_data_i (VALUE),
    .rd_en_i   (rd_en),
    .rd_data_o (fifo_rd_data),
    .count_o   (fifo_cnt),
    .full_o    (fifo_full),
    .af_o      (fifo_af)
  );

  assign fifo_empty = (fifo_cnt == '0);
  // Bytes held in lanes plus the one landing from the FIFO this cycle.
  assign n_now      = nbytes_q + NB_W'(pend_q);
  assign tmo_hit    = (TMO_CYC != 0) && (tmo_q == TMO_LIM);
  assign flush_pend = flush_q || FLUSH;

  // Packer state register plus lane, timeout and drop bookkeeping.
  always_ff @(posedge SYS_CLK) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      nbytes_q <= '0;
      lanes_q  <= '0;
      pend_q   <= 1'b0;
      flush_q  <= 1'b0;
      tmo_q    <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      nbytes_q <= nbytes_d;
      lanes_q  <= lanes_d;
      pend_q   <= rd_en;
      flush_q  <= flush_d;
      tmo_q    <= tmo_d;
      if (VALUE_WR && fifo_full && !rd_en) drop_q <= sat_inc(drop_q);
    end
  end

  // Next state: capture returning bytes, decide when a word is complete.
  always_comb begin
    state_d  = state_q;
    nbytes_d = n_now;
    lanes_d  = lanes_q;
    flush_d  = flush_pend;
    tmo_d    = tmo_q;
    if (pend_q) begin
      lanes_d[{nbytes_q[1:0], 3'b000} +: VAL_W] = fifo_rd_data;
      tmo_d = '0;
    end else if (state_q == ST_GATHER && nbytes_q != '0 && nbytes_q < NB_FULL && !tmo_hit) begin
      tmo_d = tmo_q + 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_GATHER;
        else             flush_d = 1'b0;
      end
      ST_GATHER: begin
        if (n_now == NB_FULL) begin
          state_d = ST_EMIT;
          tmo_d   = '0;
        end else if (!rd_en && n_now != '0 && (flush_pend || tmo_hit)) begin
          state_d = ST_EMIT;
          flush_d = 1'b0;
          tmo_d   = '0;
        end
      end
      ST_EMIT: begin
        if (OUT_READY) begin
          lanes_d  = '0;
          nbytes_d = '0;
          tmo_d    = '0;
          state_d  = fifo_empty ? ST_IDLE : ST_GATHER;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO read strobe; in EMIT the read goes out in the accept cycle.
  always_comb begin
    rd_en = 1'b0;
    case (state_q)
      ST_IDLE:   rd_en = !fifo_empty;
      ST_GATHER: rd_en = !fifo_empty && (n_now < NB_FULL);
      ST_EMIT:   rd_en = OUT_READY && !fifo_empty;
      default:   rd_en = 1'b0;
    endcase
  end

  assign OUT_VALID         = (state_q == ST_EMIT);
  assign OUT_DATA          = lanes_q;
  assign OUT_BYTES         = nbytes_q;
  assign DROP_CNT          = drop_q;
  assign VALUE_ALLMOSTFULL = fifo_af;

endmodule

// File: tb/tb_dbf_value_packer.sv
// Bench for dbf_value_packer: directed scenarios plus a random phase, all
// output words checked against an in-order byte queue model.
module tb_dbf_value_packer;
  localparam int ADDR_W    = 6;
  localparam int AF_THRESH = 56;
  localparam int TMO_CYC   = 255;
  localparam int DEPTH     = 1 << ADDR_W;

  logic        SYS_CLK, RESET_N, VALUE_WR, FLUSH, OUT_READY;
  logic [7:0]  VALUE;
  logic        VALUE_ALLMOSTFULL, OUT_VALID;
  logic [31:0] OUT_DATA;
  logic [2:0]  OUT_BYTES;
  logic [15:0] DROP_CNT;

  int          checks = 0;
  int          failures = 0;
  int          words_seen = 0;
  logic [31:0] last_data;
  logic [2:0]  last_bytes;
  logic [7:0]  exp_q[$];

  dbf_value_packer #(.ADDR_W(ADDR_W), .AF_THRESH(AF_THRESH), .TMO_CYC(TMO_CYC)) dut (
    .SYS_CLK(SYS_CLK), .RESET_N(RESET_N), .VALUE_WR(VALUE_WR), .VALUE(VALUE),
    .VALUE_ALLMOSTFULL(VALUE_ALLMOSTFULL), .FLUSH(FLUSH), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA), .OUT_BYTES(OUT_BYTES), .DROP_CNT(DROP_CNT)
  );

  initial SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge SYS_CLK);
    #1;
  endtask

  // Scoreboard: each accepted word must carry the next OUT_BYTES bytes in arrival order.
  always @(negedge SYS_CLK) begin : mon_blk
    logic [31:0] expw;
    int nb;
    if (RESET_N && OUT_VALID && OUT_READY) begin
      expw = '0;
      nb = int'(OUT_BYTES);
      check_val("out_bytes_range", 32'((nb >= 1) && (nb <= 4)), 32'd1);
      for (int i = 0; i < nb && i < 4; i++)
        if (exp_q.size() > 0) expw[8*i +: 8] = exp_q.pop_front();
      check_val("word", OUT_DATA, expw);
      words_seen++;
      last_data  = OUT_DATA;
      last_bytes = OUT_BYTES;
    end
  end

  task automatic put_byte(input logic [7:0] b);
    VALUE_WR = 1'b1;
    VALUE    = b;
    exp_q.push_back(b);
    tick();
    VALUE_WR = 1'b0;
  endtask

  task automatic wait_words(input int target, input int bound, input string tag);
    int n;
    n = 0;
    while (words_seen < target && n < bound) begin
      tick();
      n++;
    end
    check_val(tag, 32'(words_seen >= target), 32'd1);
  endtask

  task automatic wait_drain(input int bound, input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || OUT_VALID) && n < bound) begin
      tick();
      n++;
    end
    check_val(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int t, w0, rdy_pct;
    logic [31:0] first_word;
    RESET_N = 1'b0; VALUE_WR = 1'b0; VALUE = '0; FLUSH = 1'b0; OUT_READY = 1'b0;
    repeat (3) tick();
    check_val("rst_valid", 32'(OUT_VALID), 32'd0);
    check_val("rst_data", OUT_DATA, 32'd0);
    check_val("rst_bytes", 32'(OUT_BYTES), 32'd0);
    check_val("rst_af", 32'(VALUE_ALLMOSTFULL), 32'd0);
    check_val("rst_drop", 32'(DROP_CNT), 32'd0);
    RESET_N = 1'b1;
    tick();

    // Full word of four bytes
    OUT_READY = 1'b1;
    w0 = words_seen;
    put_byte(8'h11); put_byte(8'h22); put_byte(8'h33); put_byte(8'h44);
    wait_words(w0 + 1, 50, "t1_word_seen");
    check_val("t1_data", last_data, 32'h44332211);
    check_val("t1_bytes", 32'(last_bytes), 32'd4);
    check_val("t1_drop", 32'(DROP_CNT), 32'd0);
    wait_drain(50, "t1_drain");

    // Partial word released by timeout
    w0 = words_seen;
    put_byte(8'hAA); put_byte(8'hBB);
    t = 0;
    while (!OUT_VALID && t < 400) begin
      tick();
      t++;
    end
    check_val("tmo_window", 32'((t >= TMO_CYC - 2) && (t <= TMO_CYC + 8)), 32'd1);
    wait_words(w0 + 1, 10, "tmo_word_seen");
    check_val("tmo_data", last_data, 32'h0000BBAA);
    check_val("tmo_bytes", 32'(last_bytes), 32'd2);
    wait_drain(50, "tmo_drain");

    // Partial word released by FLUSH
    w0 = words_seen;
    put_byte(8'hCC); put_byte(8'hDD);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    t = 1;
    while (!OUT_VALID && t < 20) begin
      tick();
      t++;
    end
    check_val("flush_latency_le3", 32'(t <= 3), 32'd1);
    wait_words(w0 + 1, 10, "flush_word_seen");
    check_val("flush_data", last_data, 32'h0000DDCC);
    check_val("flush_bytes", 32'(last_bytes), 32'd2);
    wait_drain(50, "flush_drain");

    // Stalled consumer, 70 back-to-back writes: packer holds 4, FIFO 64, rest dropped
    OUT_READY = 1'b0;
    tick();
    first_word = '0;
    for (int k = 0; k < 4; k++) first_word[8*k +: 8] = 8'(k * 3 + 1);
    for (int k = 0; k < 70; k++) begin
      VALUE_WR = 1'b1;
      VALUE    = 8'(k * 3 + 1);
      if (k < DEPTH + 4) exp_q.push_back(VALUE);
      tick();
      if (k == AF_THRESH + 3) check_val("af_before", 32'(VALUE_ALLMOSTFULL), 32'd0);
      if (k == AF_THRESH + 4) check_val("af_rise", 32'(VALUE_ALLMOSTFULL), 32'd1);
      if (k == 10 || k == 40 || k == 69) begin
        check_val("stall_valid", 32'(OUT_VALID), 32'd1);
        check_val("stall_data", OUT_DATA, first_word);
      end
    end
    VALUE_WR = 1'b0;
    check_val("ovf_drop", 32'(DROP_CNT), 32'd2);
    tick(); tick();
    check_val("ovf_drop_hold", 32'(DROP_CNT), 32'd2);

    // Write into the full FIFO in the same cycle the packer reads
    OUT_READY = 1'b1;
    put_byte(8'h5A);
    check_val("full_rw_drop", 32'(DROP_CNT), 32'd2);
    wait_drain(500, "ovf_drain");
    check_val("ovf_af_clear", 32'(VALUE_ALLMOSTFULL), 32'd0);

    // Reset while a 3-byte word waits in EMIT
    OUT_READY = 1'b0;
    put_byte(8'hE1); put_byte(8'hE2); put_byte(8'hE3);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    t = 0;
    while (!OUT_VALID && t < 20) begin
      tick();
      t++;
    end
    check_val("r5_emit_bytes", 32'(OUT_BYTES), 32'd3);
    RESET_N = 1'b0;
    tick();
    check_val("r5_valid", 32'(OUT_VALID), 32'd0);
    check_val("r5_data", OUT_DATA, 32'd0);
    check_val("r5_bytes", 32'(OUT_BYTES), 32'd0);
    check_val("r5_drop", 32'(DROP_CNT), 32'd0);
    exp_q.delete();
    RESET_N = 1'b1;
    tick();
    OUT_READY = 1'b1;
    w0 = words_seen;
    put_byte(8'h51); put_byte(8'h52); put_byte(8'h53); put_byte(8'h54);
    wait_words(w0 + 1, 50, "r5_word_seen");
    check_val("r5_new_data", last_data, 32'h54535251);
    wait_drain(50, "r5_drain");

    // Random traffic honouring almost-full, random consumer and flushes
    rdy_pct = 60;
    for (int c = 0; c < 10000; c++) begin
      if (c % 500 == 0) begin
        case ($urandom_range(0, 2))
          0: rdy_pct = 10;
          1: rdy_pct = 60;
          default: rdy_pct = 100;
        endcase
      end
      OUT_READY = ($urandom_range(0, 99) < rdy_pct);
      FLUSH     = ($urandom_range(0, 49) == 0);
      VALUE_WR  = !VALUE_ALLMOSTFULL && ($urandom_range(0, 2) != 0);
      VALUE     = 8'($urandom);
      if (VALUE_WR) exp_q.push_back(VALUE);
      tick();
    end
    VALUE_WR = 1'b0;
    OUT_READY = 1'b1;
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    wait_drain(2000, "rand_drain");
    check_val("rand_drop", 32'(DROP_CNT), 32'd0);
    check_val("rand_idle_valid", 32'(OUT_VALID), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
